// File: rtl/io_seg_display.sv
// IO write latch mirrored to LEDs and scanned as 6 hex digits on a common-anode display;
// led 1 cycle after a write, an_n/seg_n 1 cycle after idx; writes always accepted, new data shown from next frame.
module io_seg_display #(
  parameter int SCAN_DIV = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_we,
  input  logic [23:0] io_wdata,
  input  logic        lz_blank,
  output logic [23:0] led,
  output logic [7:0]  seg_n,
  output logic [5:0]  an_n,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [23:0]   active_q, active_d;
  logic          pending_q, pending_d;
  logic [23:0]   led_q, led_d;
  logic [5:0]    an_n_q, an_n_d;
  logic [7:0]    seg_n_q, seg_n_d;

  logic          tc;
  logic          frame_bnd;
  logic [23:0]   upper;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tc        = (scan_cnt_q == SCAN_LAST);
  assign frame_bnd = tc && (idx_q == 3'd5);

  // Digits above the current one are all zero when the shifted word is zero.
  assign upper = active_q >> {idx_q, 2'b00};
  assign nib   = upper[3:0];

  always_comb begin
    scan_cnt_d = tc ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (tc) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    led_d     = led_q;

    // Transfer uses the pre-write shadow; a same-cycle write re-arms pending.
    if (frame_bnd && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (io_we) begin
      shadow_d  = io_wdata;
      led_d     = io_wdata;
      pending_d = 1'b1;
    end

    an_n_d = ~(6'b000001 << idx_q);
    if (lz_blank && (idx_q != 3'd0) && (upper == 24'h0)) begin
      seg_n_d = 8'hFF;
    end else begin
      seg_n_d = ~{1'b0, hex7(nib)};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      shadow_q   <= 24'h0;
      active_q   <= 24'h0;
      pending_q  <= 1'b0;
      led_q      <= 24'h0;
      an_n_q     <= 6'h3F;
      seg_n_q    <= 8'hFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      led_q      <= led_d;
      an_n_q     <= an_n_d;
      seg_n_q    <= seg_n_d;
    end
  end

  assign led        = led_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_bnd;

endmodule
